// File: rtl/uni_shift_rx_if.sv
// Parallel-side bundle of the serial frame receiver: strobe/serial input, handshake and status.
// No logic here; latency and backpressure are defined by the receiver module.
// Master drives en/sin/dir/pout_ready/clr_ovr, slave returns the received word and flags.
interface uni_shift_rx_if #(parameter int N = 4) ();
  logic         en;
  logic         sin;
  logic         dir;
  logic         pout_ready;
  logic         clr_ovr;
  logic [N-1:0] pout;
  logic         pout_valid;
  logic         parity_err;
  logic         overrun;
  logic         busy;

  modport master (
    output en, sin, dir, pout_ready, clr_ovr,
    input  pout, pout_valid, parity_err, overrun, busy
  );

  modport slave (
    input  en, sin, dir, pout_ready, clr_ovr,
    output pout, pout_valid, parity_err, overrun, busy
  );
endinterface

// File: rtl/uni_shift_rx.sv
// Serial-to-parallel receiver: start bit, N data bits (MSB or LSB first), even parity bit.
// Latency: word valid the cycle after the parity-sampling edge; a frame takes N+2 en strobes.
// Backpressure: one-word output buffer; a frame completing while the buffer is held is dropped and flagged.
module uni_shift_rx #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  uni_shift_rx_if.slave  rx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int CW = $clog2(N + 1);

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_sreg;
  logic [N-1:0]   r_pout;
  logic           r_dir_q;
  logic           r_vld;
  logic           r_perr;
  logic           r_ovr;
  logic           r_busy;

  logic           w_par_edge;
  logic           w_free;
  logic           w_deliver;
  logic           w_drop;
  logic           w_consume;
  logic           w_mismatch;

  // A consume on the same edge frees the buffer for the incoming word.
  assign w_consume  = r_vld && rx.pout_ready;
  assign w_free     = !r_vld || rx.pout_ready;
  assign w_par_edge = (r_state == PARITY) && rx.en;
  assign w_deliver  = w_par_edge && w_free;
  assign w_drop     = w_par_edge && !w_free;
  assign w_mismatch = (^r_sreg) ^ rx.sin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_dir_q <= 1'b0;
      r_busy  <= 1'b0;
      r_pout  <= '0;
      r_vld   <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (rx.en) begin
        case (r_state)
          IDLE: begin
            if (rx.sin) begin
              r_dir_q <= rx.dir;
              r_cnt   <= '0;
              r_sreg  <= '0;
              r_busy  <= 1'b1;
              r_state <= DATA;
            end
          end
          DATA: begin
            if (r_dir_q)
              r_sreg <= {rx.sin, r_sreg[N-1:1]};
            else
              r_sreg <= {r_sreg[N-2:0], rx.sin};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1))
              r_state <= PARITY;
          end
          PARITY: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end

      if (w_deliver) begin
        r_pout <= r_sreg;
        r_perr <= w_mismatch;
        r_vld  <= 1'b1;
      end else if (w_consume) begin
        r_vld  <= 1'b0;
      end

      // Set wins over a simultaneous clear.
      if (w_drop)
        r_ovr <= 1'b1;
      else if (rx.clr_ovr)
        r_ovr <= 1'b0;
    end
  end

  assign rx.pout       = r_pout;
  assign rx.pout_valid = r_vld;
  assign rx.parity_err = r_perr;
  assign rx.overrun    = r_ovr;
  assign rx.busy       = r_busy;

endmodule
